jump_control: RTL and testbench

//   Branch-decision unit of the KGPminiRISC datapath. Evaluates the 3-bit branch

---
 rtl/jump_control_pkg.sv | 24 ++
 rtl/jump_cond_decode.sv | 34 +++
 rtl/jump_control.sv | 40 ++++
 tb/tb_jump_control.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jump_control_pkg.sv
// -----------------------------------------------------------------------------
// jump_control_pkg
//   Shared constants for the KGPminiRISC branch-decision logic.
//   - CJ_* : 3-bit branch condition codes produced by the decoder.
//   - FLAG_* : bit positions of the ALU status flags within the 3-bit flag bus.
// -----------------------------------------------------------------------------
package jump_control_pkg;

  // Branch condition codes (CondJump encoding)
  localparam logic [2:0] CJ_NONE = 3'b000;  // no branch
  localparam logic [2:0] CJ_B    = 3'b001;  // b / bl, unconditional
  localparam logic [2:0] CJ_BLTZ = 3'b010;  // branch if negative
  localparam logic [2:0] CJ_BZ   = 3'b011;  // branch if zero
  localparam logic [2:0] CJ_BNZ  = 3'b100;  // branch if not zero
  localparam logic [2:0] CJ_BCY  = 3'b101;  // branch if carry
  localparam logic [2:0] CJ_BNCY = 3'b110;  // branch if no carry
  localparam logic [2:0] CJ_RSVD = 3'b111;  // reserved, never branches

  // ALU status flag bit positions
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 0;

endpackage : jump_control_pkg

// File: rtl/jump_cond_decode.sv
// -----------------------------------------------------------------------------
// jump_cond_decode
//   Purely combinational branch condition evaluation: selects the ALU flag
//   (or constant) that the current condition code depends on.
// Ports:
//   flag      in  [2:0]  ALU status: [2]=carry, [1]=zero, [0]=sign
//   CondJump  in  [2:0]  branch condition code from the decoder
//   jc_next   out        1 = branch condition satisfied this cycle
// -----------------------------------------------------------------------------
module jump_cond_decode
  import jump_control_pkg::*;
(
  input  logic [2:0] flag,
  input  logic [2:0] CondJump,
  output logic       jc_next
);

  // Decode the condition code against the relevant flag only
  always_comb begin
    jc_next = 1'b0;
    case (CondJump)
      CJ_NONE: jc_next = 1'b0;
      CJ_B:    jc_next = 1'b1;
      CJ_BLTZ: jc_next = flag[FLAG_SIGN];
      CJ_BZ:   jc_next = flag[FLAG_ZERO];
      CJ_BNZ:  jc_next = ~flag[FLAG_ZERO];
      CJ_BCY:  jc_next = flag[FLAG_CARRY];
      CJ_BNCY: jc_next = ~flag[FLAG_CARRY];
      CJ_RSVD: jc_next = 1'b0;
      default: jc_next = 1'b0;
    endcase
  end

endmodule : jump_cond_decode

// File: rtl/jump_control.sv
// -----------------------------------------------------------------------------
// jump_control
//   Branch-decision unit of the KGPminiRISC datapath. Evaluates the branch
//   condition code against the ALU flags and registers the "take jump" strobe
//   used by PC-select to choose the branch target over PC+4.
// Ports:
//   clk       in         system clock, rising edge
//   rst       in         synchronous, active-high reset
//   flag      in  [2:0]  ALU status: [2]=carry, [1]=zero, [0]=sign
//   CondJump  in  [2:0]  branch condition code from the decoder
//   JCout     out        1 = take the jump (one cycle after the inputs)
// -----------------------------------------------------------------------------
module jump_control
  import jump_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] flag,
  input  logic [2:0] CondJump,
  output logic       JCout
);

  logic jc_next_s;

  jump_cond_decode u_decode (
    .flag     (flag),
    .CondJump (CondJump),
    .jc_next  (jc_next_s)
  );

  // Output register; reset has priority over any pending decision
  always_ff @(posedge clk) begin
    if (rst) begin
      JCout <= 1'b0;
    end else begin
      JCout <= jc_next_s;
    end
  end

endmodule : jump_control

// File: tb/tb_jump_control.sv
module tb_jump_control;

  logic       clk;
  logic       rst;
  logic [2:0] flag;
  logic [2:0] CondJump;
  logic       JCout;

  int checks;
  int failures;

  jump_control dut (
    .clk      (clk),
    .rst      (rst),
    .flag     (flag),
    .CondJump (CondJump),
    .JCout    (JCout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which flag (by name) a branch tests and whether it is inverted,
  // expressed as a decision from the mnemonic rules of the ISA.
  function automatic logic model(input int code, input logic [2:0] f);
    logic carry, zero, sign;
    carry = f[2];
    zero  = f[1];
    sign  = f[0];
    if (code == 1) return 1'b1;          // b / bl
    else if (code == 2) return sign;     // bltz
    else if (code == 3) return zero;     // bz
    else if (code == 4) return !zero;    // bnz
    else if (code == 5) return carry;    // bcy
    else if (code == 6) return !carry;   // bncy
    else return 1'b0;                    // none / reserved
  endfunction

  // Apply inputs, clock once, sample 1 time unit after the edge
  task automatic apply(input logic r, input logic [2:0] cj, input logic [2:0] f);
    rst = r;
    CondJump = cj;
    flag = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 3'b001, 3'b000);
      checks++;
      if (JCout !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%b exp=0", i, JCout);
      end
    end
    apply(1'b0, 3'b001, 3'b000);
    checks++;
    if (JCout !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got=%b exp=1", JCout);
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic e;
        apply(1'b0, 3'(c), 3'(f));
        e = model(c, 3'(f));
        checks++;
        if (JCout !== e) begin
          failures++;
          $display("FAIL sweep code=%0d flag=%0d got=%b exp=%b", c, f, JCout, e);
        end
      end
    end
  endtask

  task automatic test_boundary();
    apply(1'b0, 3'b000, 3'b111);
    checks++;
    if (JCout !== 1'b0) begin
      failures++;
      $display("FAIL none_allflags got=%b exp=0", JCout);
    end
    apply(1'b0, 3'b111, 3'b111);
    checks++;
    if (JCout !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_allflags got=%b exp=0", JCout);
    end
    apply(1'b0, 3'b001, 3'b000);
    checks++;
    if (JCout !== 1'b1) begin
      failures++;
      $display("FAIL uncond_noflags got=%b exp=1", JCout);
    end
  endtask

  task automatic test_latency();
    logic prev;
    apply(1'b0, 3'b100, 3'b010);   // bnz with zero set -> 0
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] cj;
      logic e;
      cj = (i % 2 == 0) ? 3'b011 : 3'b100;
      e  = (i % 2 == 0) ? 1'b1 : 1'b0;
      rst = 1'b0;
      CondJump = cj;
      flag = 3'b010;
      #1;
      checks++;
      if (JCout !== prev) begin
        failures++;
        $display("FAIL latency_hold step=%0d got=%b exp=%b", i, JCout, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (JCout !== e) begin
        failures++;
        $display("FAIL latency_update step=%0d got=%b exp=%b", i, JCout, e);
      end
      prev = e;
    end
  endtask

  task automatic test_midrun_reset();
    logic [0:0] exp_seq [4];
    logic [0:0] rst_seq [4];
    rst_seq = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      apply(rst_seq[i], 3'b001, 3'b000);
      checks++;
      if (JCout !== exp_seq[i]) begin
        failures++;
        $display("FAIL midrun_reset step=%0d got=%b exp=%b", i, JCout, exp_seq[i]);
      end
    end
  endtask

  task automatic test_irrelevant_flags();
    apply(1'b0, 3'b101, 3'b011);
    checks++;
    if (JCout !== 1'b0) begin
      failures++;
      $display("FAIL bcy_nocarry got=%b exp=0", JCout);
    end
    apply(1'b0, 3'b101, 3'b100);
    checks++;
    if (JCout !== 1'b1) begin
      failures++;
      $display("FAIL bcy_carry got=%b exp=1", JCout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic [2:0] cj, f;
      logic e;
      r  = ($urandom_range(0, 15) == 0);
      cj = 3'($urandom_range(0, 7));
      f  = 3'($urandom_range(0, 7));
      e  = r ? 1'b0 : model(int'(cj), f);
      apply(r, cj, f);
      checks++;
      if (JCout !== e) begin
        failures++;
        $display("FAIL random i=%0d rst=%b code=%0d flag=%0d got=%b exp=%b",
                 i, r, cj, f, JCout, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    CondJump = 3'b001;
    flag = 3'b000;
    test_reset();
    test_sweep();
    test_boundary();
    test_latency();
    test_midrun_reset();
    test_irrelevant_flags();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_jump_control
